// File: rtl/ctrl_pkg.sv
// Shared types for the RV32I multi-cycle controller: opcodes, mux-select enums,
// FSM state encoding and the one-hot instruction class.
package ctrl_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_U    = 3'd3,
      IMM_J    = 3'd4,
      IMM_NONE = 3'd7
   } imm_sel_e;

   typedef enum logic {
      PC_PLUS4 = 1'b0,
      PC_ALU   = 1'b1
   } pc_sel_e;

   typedef enum logic [1:0] {
      ALU_A_RS1  = 2'd0,
      ALU_A_PC   = 2'd1,
      ALU_A_ZERO = 2'd2
   } alu_a_sel_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_FWAIT  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MREQ   = 3'd4,
      S_MWAIT  = 3'd5,
      S_WB     = 3'd6,
      S_TRAP   = 3'd7
   } state_e;

   typedef struct packed {
      logic load;
      logic store;
      logic branch;
      logic op_imm;
      logic op;
      logic lui;
      logic auipc;
      logic jal;
      logic jalr;
   } op_class_t;

endpackage

// File: rtl/ctrl_op_class.sv
// Opcode decoder: inst[6:0] -> one-hot instruction class and immediate-type select.
module ctrl_op_class
   import ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   output op_class_t  o_cls,
   output logic       o_legal,
   output imm_sel_e   o_imm_sel
);

   always_comb begin
      o_cls     = '0;
      o_imm_sel = IMM_NONE;
      case (i_opcode)
         OPC_LOAD:   begin o_cls.load   = 1'b1; o_imm_sel = IMM_I; end
         OPC_STORE:  begin o_cls.store  = 1'b1; o_imm_sel = IMM_S; end
         OPC_BRANCH: begin o_cls.branch = 1'b1; o_imm_sel = IMM_B; end
         OPC_OP_IMM: begin o_cls.op_imm = 1'b1; o_imm_sel = IMM_I; end
         OPC_OP:     begin o_cls.op     = 1'b1; o_imm_sel = IMM_NONE; end
         OPC_LUI:    begin o_cls.lui    = 1'b1; o_imm_sel = IMM_U; end
         OPC_AUIPC:  begin o_cls.auipc  = 1'b1; o_imm_sel = IMM_U; end
         OPC_JAL:    begin o_cls.jal    = 1'b1; o_imm_sel = IMM_J; end
         OPC_JALR:   begin o_cls.jalr   = 1'b1; o_imm_sel = IMM_I; end
         default:    ;
      endcase
   end

   assign o_legal = |o_cls;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I main controller with imem/dmem handshakes and retire counter.
// Build option MC_ILLEGAL_TRAP_EN: unknown opcodes park in S_TRAP (adds port illegal).
//
// state    | meaning
// S_FETCH  | imem_req high until granted
// S_FWAIT  | wait for fetch data, latch IR on imem_rvalid
// S_DECODE | IR stable, immediate type presented
// S_EXEC   | ALU operands selected; branches retire here
// S_MREQ   | dmem_req high until granted
// S_MWAIT  | wait for load data / store ack; stores retire here
// S_WB     | register writeback and PC update, retire
// S_TRAP   | illegal opcode parked until reset (trap build only)
module mc_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          inst,
   input  logic                 br_taken,
   output logic                 imem_req,
   input  logic                 imem_gnt,
   input  logic                 imem_rvalid,
   output logic                 dmem_req,
   output logic                 dmem_we,
   input  logic                 dmem_gnt,
   input  logic                 dmem_rvalid,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic                 pc_sel,
   output logic [2:0]           imm_sel,
   output logic [1:0]           alu_a_sel,
   output logic                 alu_b_sel,
   output logic [1:0]           wb_sel,
   output logic                 reg_we,
   output logic                 instret,
   output logic [INSTRET_W-1:0] instret_cnt
`ifdef MC_ILLEGAL_TRAP_EN
   ,
   output logic                 illegal
`endif
);

   state_e                r_state;
   logic [INSTRET_W-1:0]  r_instret_cnt;

   op_class_t  w_cls;
   logic       w_legal;
   imm_sel_e   w_cls_imm;
   logic       w_unused_inst;

   logic       w_imem_req, w_ir_we, w_pc_we, w_alu_b, w_dmem_req, w_dmem_we;
   logic       w_reg_we, w_instret;
   pc_sel_e    w_pc_sel;
   imm_sel_e   w_imm_sel;
   alu_a_sel_e w_alu_a;
   wb_sel_e    w_wb_sel;

   assign w_unused_inst = ^inst[31:7];

   ctrl_op_class u_op_class (
      .i_opcode  (inst[6:0]),
      .o_cls     (w_cls),
      .o_legal   (w_legal),
      .o_imm_sel (w_cls_imm)
   );

   // Outputs depend only on state, opcode and the rvalid/br_taken qualifiers;
   // requests never see a gnt, so there is no gnt->req loop through the memories.
   always_comb begin
      w_imem_req = 1'b0;
      w_ir_we    = 1'b0;
      w_pc_we    = 1'b0;
      w_pc_sel   = PC_PLUS4;
      w_imm_sel  = IMM_NONE;
      w_alu_a    = ALU_A_RS1;
      w_alu_b    = 1'b0;
      w_dmem_req = 1'b0;
      w_dmem_we  = 1'b0;
      w_wb_sel   = WB_ALU;
      w_reg_we   = 1'b0;
      w_instret  = 1'b0;
      if (!rst) begin
         case (r_state)
            S_FETCH:  w_imem_req = 1'b1;
            S_FWAIT:  w_ir_we    = imem_rvalid;
            S_DECODE: w_imm_sel  = w_cls_imm;
            S_EXEC: begin
               w_imm_sel = w_cls_imm;
               w_alu_b   = ~w_cls.op;
               if (w_cls.lui)
                  w_alu_a = ALU_A_ZERO;
               else if (w_cls.auipc || w_cls.jal || w_cls.branch)
                  w_alu_a = ALU_A_PC;
               if (w_cls.branch) begin
                  w_pc_we   = 1'b1;
                  w_pc_sel  = br_taken ? PC_ALU : PC_PLUS4;
                  w_instret = 1'b1;
               end
            end
            S_MREQ: begin
               w_imm_sel  = w_cls_imm;
               w_dmem_req = 1'b1;
               w_dmem_we  = w_cls.store;
            end
            S_MWAIT: begin
               w_imm_sel = w_cls_imm;
               if (dmem_rvalid && w_cls.store) begin
                  w_pc_we   = 1'b1;
                  w_instret = 1'b1;
               end
            end
            S_WB: begin
               w_imm_sel = w_cls_imm;
               w_reg_we  = w_legal;
               w_pc_we   = 1'b1;
               w_instret = 1'b1;
               if (w_cls.load)
                  w_wb_sel = WB_MEM;
               else if (w_cls.jal || w_cls.jalr)
                  w_wb_sel = WB_PC4;
               if (w_cls.jal || w_cls.jalr)
                  w_pc_sel = PC_ALU;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_FETCH;
         r_instret_cnt <= '0;
      end else begin
         if (w_instret)
            r_instret_cnt <= r_instret_cnt + INSTRET_W'(1);
         case (r_state)
            S_FETCH:  if (imem_gnt)    r_state <= S_FWAIT;
            S_FWAIT:  if (imem_rvalid) r_state <= S_DECODE;
            S_DECODE: begin
`ifdef MC_ILLEGAL_TRAP_EN
               r_state <= w_legal ? S_EXEC : S_TRAP;
`else
               r_state <= w_legal ? S_EXEC : S_WB;
`endif
            end
            S_EXEC: begin
               if (w_cls.branch)
                  r_state <= S_FETCH;
               else if (w_cls.load || w_cls.store)
                  r_state <= S_MREQ;
               else
                  r_state <= S_WB;
            end
            S_MREQ:   if (dmem_gnt) r_state <= S_MWAIT;
            S_MWAIT:  if (dmem_rvalid) r_state <= w_cls.store ? S_FETCH : S_WB;
            S_WB:     r_state <= S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:   r_state <= S_TRAP;
`endif
            default:  r_state <= S_FETCH;
         endcase
      end
   end

   assign imem_req    = w_imem_req;
   assign ir_we       = w_ir_we;
   assign pc_we       = w_pc_we;
   assign pc_sel      = w_pc_sel;
   assign imm_sel     = w_imm_sel;
   assign alu_a_sel   = w_alu_a;
   assign alu_b_sel   = w_alu_b;
   assign dmem_req    = w_dmem_req;
   assign dmem_we     = w_dmem_we;
   assign wb_sel      = w_wb_sel;
   assign reg_we      = w_reg_we;
   assign instret     = w_instret;
   assign instret_cnt = r_instret_cnt;
`ifdef MC_ILLEGAL_TRAP_EN
   assign illegal     = ~rst && (r_state == S_TRAP);
`endif

endmodule
